rx_lbuf_sched: RTL and testbench

- Ping-pong scheduler between the two host-armed large buffers (lbuf1, lbuf2) and the single RX DMA write engine.
- Sits between rx_hst_ctrl (slot arm/done) and the DMA engine (lbuf_addr/lbuf_en/lbuf64b/lbuf_dn).
- Issues slots in strict alternation, holds each until the engine reports done, then returns a done pulse to the owning slot.
- Blocks reuse of a slot until the host has visibly re-armed it.

---
 rtl/rx_lbuf_sched.sv | 148 ++++++++++++++
 tb/tb_rx_lbuf_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lbuf_sched.sv
// Ping-pong scheduler handing lbuf1/lbuf2 to the RX DMA engine in strict turn.
// Optional counters enabled by defining RX_LBUF_SCHED_STATS_EN.
module rx_lbuf_sched #(
    parameter int FIRST_SLOT  = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] lbuf1_addr,
    input  logic        lbuf1_en,
    output logic        lbuf1_dn,
    input  logic [63:0] lbuf2_addr,
    input  logic        lbuf2_en,
    output logic        lbuf2_dn,
    output logic [63:0] lbuf_addr,
    output logic        lbuf_en,
    output logic        lbuf64b,
    input  logic        lbuf_dn
`ifdef RX_LBUF_SCHED_STATS_EN
    ,
    output logic [31:0]            lbuf_issued_cnt,
    output logic [STALL_CNT_W-1:0] lbuf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        WAIT1,
        ISSUE1,
        WAIT2,
        ISSUE2
    } state_t;

    localparam state_t RstState = (FIRST_SLOT == 2) ? WAIT2 : WAIT1;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        en_q, en_d;
    logic        b64_q, b64_d;
    logic        dn1_q, dn1_d;
    logic        dn2_q, dn2_d;
    logic        stale1_q, stale1_d;
    logic        stale2_q, stale2_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        en_d     = en_q;
        b64_d    = b64_q;
        dn1_d    = 1'b0;
        dn2_d    = 1'b0;
        // A slot is visibly re-armed only once its en has been seen low.
        stale1_d = stale1_q & lbuf1_en;
        stale2_d = stale2_q & lbuf2_en;
        case (state_q)
            WAIT1: begin
                if (lbuf1_en && !stale1_q) begin
                    state_d = ISSUE1;
                    en_d    = 1'b1;
                    addr_d  = lbuf1_addr;
                    b64_d   = |lbuf1_addr[63:32];
                end
            end
            ISSUE1: begin
                if (lbuf_dn) begin
                    state_d  = WAIT2;
                    en_d     = 1'b0;
                    dn1_d    = 1'b1;
                    stale1_d = 1'b1;
                end
            end
            WAIT2: begin
                if (lbuf2_en && !stale2_q) begin
                    state_d = ISSUE2;
                    en_d    = 1'b1;
                    addr_d  = lbuf2_addr;
                    b64_d   = |lbuf2_addr[63:32];
                end
            end
            ISSUE2: begin
                if (lbuf_dn) begin
                    state_d  = WAIT1;
                    en_d     = 1'b0;
                    dn2_d    = 1'b1;
                    stale2_d = 1'b1;
                end
            end
            default: state_d = RstState;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RstState;
            addr_q   <= '0;
            en_q     <= 1'b0;
            b64_q    <= 1'b0;
            dn1_q    <= 1'b0;
            dn2_q    <= 1'b0;
            stale1_q <= 1'b0;
            stale2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            b64_q    <= b64_d;
            dn1_q    <= dn1_d;
            dn2_q    <= dn2_d;
            stale1_q <= stale1_d;
            stale2_q <= stale2_d;
        end
    end

    assign lbuf_addr = addr_q;
    assign lbuf_en   = en_q;
    assign lbuf64b   = b64_q;
    assign lbuf1_dn  = dn1_q;
    assign lbuf2_dn  = dn2_q;

`ifdef RX_LBUF_SCHED_STATS_EN
    logic [31:0]            iss_q, iss_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   stall_c;

    always_comb begin
        stall_c = ((state_q == WAIT1) && (!lbuf1_en || stale1_q)) ||
                  ((state_q == WAIT2) && (!lbuf2_en || stale2_q));
        iss_d   = iss_q + {31'd0, (dn1_d | dn2_d)};
        stall_d = stall_q;
        if (stall_c && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_q   <= '0;
            stall_q <= '0;
        end else begin
            iss_q   <= iss_d;
            stall_q <= stall_d;
        end
    end

    assign lbuf_issued_cnt = iss_q;
    assign lbuf_stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_rx_lbuf_sched.sv
// Bench for rx_lbuf_sched: directed table, reset corner cases, random vs model.
// Counter checks are compiled in when RX_LBUF_SCHED_STATS_EN is defined.
module tb_rx_lbuf_sched;

    localparam int SW = 4;
    localparam logic [63:0] A1 = 64'h0000_0001_2000_0000;
    localparam logic [63:0] A2 = 64'h0000_0000_1000_0000;
    localparam logic [63:0] AX = 64'hFFFF_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] lbuf1_addr = '0;
    logic        lbuf1_en = 1'b0;
    logic        lbuf1_dn;
    logic [63:0] lbuf2_addr = '0;
    logic        lbuf2_en = 1'b0;
    logic        lbuf2_dn;
    logic [63:0] lbuf_addr;
    logic        lbuf_en;
    logic        lbuf64b;
    logic        lbuf_dn = 1'b0;
`ifdef RX_LBUF_SCHED_STATS_EN
    logic [31:0] lbuf_issued_cnt;
    logic [SW-1:0] lbuf_stall_cnt;
`endif

    rx_lbuf_sched #(.FIRST_SLOT(1), .STALL_CNT_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .lbuf1_addr (lbuf1_addr),
        .lbuf1_en   (lbuf1_en),
        .lbuf1_dn   (lbuf1_dn),
        .lbuf2_addr (lbuf2_addr),
        .lbuf2_en   (lbuf2_en),
        .lbuf2_dn   (lbuf2_dn),
        .lbuf_addr  (lbuf_addr),
        .lbuf_en    (lbuf_en),
        .lbuf64b    (lbuf64b),
        .lbuf_dn    (lbuf_dn)
`ifdef RX_LBUF_SCHED_STATS_EN
        ,
        .lbuf_issued_cnt (lbuf_issued_cnt),
        .lbuf_stall_cnt  (lbuf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic xen,
                           input logic [63:0] xaddr, input logic x64,
                           input logic xd1, input logic xd2);
        check({nm, ".en"}, {63'd0, lbuf_en}, {63'd0, xen});
        check({nm, ".addr"}, lbuf_addr, xaddr);
        check({nm, ".64b"}, {63'd0, lbuf64b}, {63'd0, x64});
        check({nm, ".dn1"}, {63'd0, lbuf1_dn}, {63'd0, xd1});
        check({nm, ".dn2"}, {63'd0, lbuf2_dn}, {63'd0, xd2});
    endtask

    typedef struct {
        logic        en1;
        logic        en2;
        logic [63:0] a1;
        logic [63:0] a2;
        logic        dn;
        logic        xen;
        logic [63:0] xaddr;
        logic        x64;
        logic        xd1;
        logic        xd2;
    } vec_t;

    vec_t tbl[11];

    // Reference model: who owns the engine, whose turn it is, stale flags.
    int          m_owner;
    int          m_turn;
    bit          m_stale[3];
    logic        m_en;
    logic [63:0] m_addr;
    logic        m_64;
    logic        m_d1;
    logic        m_d2;
    longint      m_iss;
    int          m_stall;

    task automatic m_reset();
        m_owner = 0;
        m_turn = 1;
        m_stale[1] = 0;
        m_stale[2] = 0;
        m_en = 0;
        m_addr = '0;
        m_64 = 0;
        m_d1 = 0;
        m_d2 = 0;
        m_iss = 0;
        m_stall = 0;
    endtask

    task automatic m_step(input bit e1, input bit e2, input logic [63:0] a1,
                          input logic [63:0] a2, input bit dn);
        bit          en[3];
        logic [63:0] ad[3];
        int          done;
        en[1] = e1;
        en[2] = e2;
        ad[1] = a1;
        ad[2] = a2;
        done = 0;
        m_d1 = 0;
        m_d2 = 0;
        if (m_owner == 0 && (!en[m_turn] || m_stale[m_turn]))
            m_stall = (m_stall == (1 << SW) - 1) ? m_stall : m_stall + 1;
        if (m_owner != 0) begin
            if (dn) begin
                done = m_owner;
                m_en = 0;
                if (m_owner == 1) m_d1 = 1;
                else m_d2 = 1;
                m_iss++;
                m_turn = 3 - m_owner;
                m_owner = 0;
            end
        end else if (en[m_turn] && !m_stale[m_turn]) begin
            m_owner = m_turn;
            m_en = 1;
            m_addr = ad[m_turn];
            m_64 = (ad[m_turn][63:32] != 0);
        end
        for (int n = 1; n <= 2; n++) begin
            if (done == n) m_stale[n] = 1;
            else if (!en[n]) m_stale[n] = 0;
        end
    endtask

    initial begin
        int hits;
        bit e1, e2, dn;
        logic [63:0] a1, a2;

        tbl[0]  = '{1, 1, A1, A2, 0, 1, A1, 1, 0, 0};
        tbl[1]  = '{1, 1, A1, A2, 1, 0, A1, 1, 1, 0};
        tbl[2]  = '{1, 1, A1, A2, 0, 1, A2, 0, 0, 0};
        tbl[3]  = '{1, 1, A1, AX, 0, 1, A2, 0, 0, 0};
        tbl[4]  = '{1, 1, A1, AX, 1, 0, A2, 0, 0, 1};
        tbl[5]  = '{1, 1, A1, A2, 0, 0, A2, 0, 0, 0};
        tbl[6]  = '{1, 1, A1, A2, 0, 0, A2, 0, 0, 0};
        tbl[7]  = '{0, 1, A1, A2, 1, 0, A2, 0, 0, 0};
        tbl[8]  = '{1, 1, A1, A2, 0, 1, A1, 1, 0, 0};
        tbl[9]  = '{1, 1, A1, A2, 1, 0, A1, 1, 1, 0};
        tbl[10] = '{1, 1, A1, A2, 0, 0, A1, 1, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, '0, 0, 0, 0);
        rst = 1'b0;

        // Only slot 2 armed while slot 1 owns the turn: nothing issues.
        lbuf2_en = 1'b1;
        lbuf2_addr = A2;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (lbuf_en) hits++;
        end
        check("wait1_blocks_slot2", 64'(hits), 64'd0);
`ifdef RX_LBUF_SCHED_STATS_EN
        check("stall_sat", 64'(lbuf_stall_cnt), 64'd15);
`endif

        for (int i = 0; i < 11; i++) begin
            lbuf1_en = tbl[i].en1;
            lbuf2_en = tbl[i].en2;
            lbuf1_addr = tbl[i].a1;
            lbuf2_addr = tbl[i].a2;
            lbuf_dn = tbl[i].dn;
            @(posedge clk);
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].xen, tbl[i].xaddr,
                    tbl[i].x64, tbl[i].xd1, tbl[i].xd2);
        end

        // Re-arm slot 2, then reset in the middle of its issue.
        lbuf_dn = 1'b0;
        lbuf2_en = 1'b0;
        @(posedge clk);
        #1;
        lbuf2_en = 1'b1;
        @(posedge clk);
        #1;
        check("issue2_before_rst", {63'd0, lbuf_en}, 64'd1);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, '0, 0, 0, 0);
        lbuf1_en = 1'b0;
        lbuf2_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (lbuf2_dn || lbuf1_dn || lbuf_en) hits++;
        end
        check("no_dn_after_rst", 64'(hits), 64'd0);

        // Random traffic against the model, starting from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            e1 = ($urandom_range(0, 3) != 0);
            e2 = ($urandom_range(0, 3) != 0);
            a1 = {($urandom_range(0, 1) != 0) ? $urandom : 32'd0, $urandom};
            a2 = {($urandom_range(0, 1) != 0) ? $urandom : 32'd0, $urandom};
            dn = ($urandom_range(0, 2) == 0);
            lbuf1_en = e1;
            lbuf2_en = e2;
            lbuf1_addr = a1;
            lbuf2_addr = a2;
            lbuf_dn = dn;
            @(posedge clk);
            m_step(e1, e2, a1, a2, dn);
            #1;
            if (m_en !== lbuf_en || m_d1 !== lbuf1_dn || m_d2 !== lbuf2_dn ||
                (m_en && (m_addr !== lbuf_addr || m_64 !== lbuf64b))) begin
                chk_out($sformatf("rand%0d", i), m_en, m_addr, m_64, m_d1,
                        m_d2);
            end else begin
                checks++;
            end
`ifdef RX_LBUF_SCHED_STATS_EN
            check("issued_cnt", 64'(lbuf_issued_cnt), 64'(m_iss[31:0]));
            check("stall_cnt", 64'(lbuf_stall_cnt), 64'(m_stall));
`endif
        end
`ifdef RX_LBUF_SCHED_STATS_EN
        if (m_iss < 3) check("issued_ge3", 64'(m_iss), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
